spi_master_burst: RTL
=====================

Name: spi_master_burst

Overview:
Parametrised, runtime-configurable SPI master that replaces the fixed-mode, fixed-width, single-CS master.
- Supports all four SPI modes, per-burst word width, per-burst clock divider and N chip selects, all selected at run time.
- Supports multi-word bursts: CS stays asserted across words until the MOSI word carrying tlast completes.
- Sits between an AXI-stream command/data source and the board SPI pins; MISO words return on a second AXI stream with matching tlast.

Parameters:
MAX_WIDTH, 32, maximum bits per word; tdata width of both streams
NUM_CS, 4, number of active-low chip selects
DIV_WIDTH, 16, width of cfg_clk_div

Ports:
clk  in  1  system clock; every register is clocked on its rising edge
reset  in  1  asynchronous, active-low reset
cfg_cpol  in  1  sck idle level
cfg_cpha  in  1  0: sample on first edge of each bit; 1: shift on first edge, sample on second
cfg_clk_div  in  DIV_WIDTH  sck half-period H in clk cycles; 0 is treated as 1
cfg_width  in  $clog2(MAX_WIDTH)+1  bits per word W, 1..MAX_WIDTH; 0 or >MAX_WIDTH clamps to MAX_WIDTH
cfg_cs_sel  in  $clog2(NUM_CS) (min 1)  chip select index; out of range selects none, but the burst still clocks
mosi_tdata  in  MAX_WIDTH  word to send, right-aligned
mosi_tvalid  in  1  AXI-stream valid
mosi_tready  out  1  AXI-stream ready
mosi_tlast  in  1  last word of burst
miso_tdata  out  MAX_WIDTH  received word, right-aligned, upper bits zero
miso_tvalid  out  1  AXI-stream valid
miso_tready  in  1  AXI-stream ready
miso_tlast  out  1  copy of the tlast of the corresponding MOSI word
sck  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in, sampled directly with no synchroniser
cs_n  out  NUM_CS  chip selects, active low
busy  out  1  high from first-word accept until the CS_IDLE state exits

Behaviour:
- Reset (asynchronous, active-low), including mid-word:
  - cs_n all 1; sck 0; mosi 0; mosi_tready 0; miso_tvalid 0; miso_tdata 0; miso_tlast 0; busy 0; state IDLE.
  - No partial word is emitted.
  - On the first clk after release, sck goes to cfg_cpol.
- Data format:
  - MSB-first; bit W-1 of tdata is shifted first.
  - MISO bits shift in at bit 0, so the final word is right-aligned.
- State machine: IDLE -> CS_SETUP -> SHIFT -> (NEXT -> SHIFT)* -> CS_HOLD -> CS_IDLE -> IDLE.
- IDLE:
  - sck = cfg_cpol. mosi_tready = !miso_tvalid.
  - On handshake, latch cpol, cpha, H, W, cs_sel, data and last. These are frozen for the whole burst; cfg_* changes mid-burst are ignored.
  - Drive the selected cs_n low. If cpha=0, mosi = data[W-1].
  - Go to CS_SETUP.
- CS_SETUP: H cycles, then SHIFT.
- SHIFT:
  - sck toggles every H cycles, giving exactly 2W edges per word. Word duration is 2*W*H cycles.
  - Sample edges are odd edges (1, 3, ...) when cpha=0 and even edges when cpha=1. The other edges shift the next bit onto mosi.
  - cpha=1: the first edge drives data[W-1].
  - After edge 2W, sck is at its latched cpol level. Push the word: miso_tvalid=1, miso_tdata, miso_tlast=last.
  - If last, go to CS_HOLD; otherwise go to NEXT.
- NEXT:
  - CS stays low and sck stays at its latched cpol level.
  - mosi_tready = !miso_tvalid. This stalls the bus on MISO backpressure, so a received word is never overwritten.
  - On handshake, latch data and last (cpha=0: drive mosi = data[W-1]), then go to SHIFT.
  - Waiting in NEXT for an empty MOSI stream is unbounded and legal.
- CS_HOLD: H cycles, then all cs_n = 1.
- CS_IDLE: H cycles with CS high (minimum deselect time), then IDLE.
- MISO output: single-entry register. miso_tvalid clears on handshake. Push and pop never coincide, because a new word starts only while the register is empty.
- Handshakes: mosi_tready is registered and deasserts in the cycle after the handshake, so at most one word is accepted per NEXT/IDLE visit.
- Counters:
  - Half-period counter is DIV_WIDTH bits and compares against H-1.
  - Edge counter is $clog2(2*MAX_WIDTH)+1 bits.
  - No wrap is possible within a word.

Test Plan:
- Mode 0, W=8, H=2, cs_sel=0, tdata 0xA5, tlast=1, miso looped to mosi -> cs_n[0] low for 36 cycles (2+32+2); 16 sck edges; miso_tdata 0x000000A5, miso_tlast 1; others cs_n stay high.
- Mode 3, W=12, H=1, cs_sel=2, burst 0xABC, 0x123, 0xFFF (tlast on third), miso looped -> cs_n[2] continuously low; 72 sck edges; three MISO words returned in order, tlast only on 0xFFF.
- Mode 1 and mode 2, W=1 and W=32, tdata 0x80000001 -> correct shift/sample edge per mode; W=32 returns 0x80000001; W=1 returns 0x1 with upper bits zero.
- miso_tready held low for 100 cycles after word 1 of a 2-word burst -> sck frozen at cpol, cs_n held low, mosi_tready low; after release, word 2 completes and data is intact.
- Reset asserted mid-SHIFT, word 3 of 4 -> cs_n all 1 and sck 0 immediately; no miso_tvalid; a fresh burst after release behaves as in the first scenario.
- cfg_clk_div=0, cfg_width changed mid-burst -> H treated as 1; latched W is used for every word of that burst.

Source files
------------

// File: rtl/spi_master_burst.sv
// SPI master with run-time mode, word width, clock divider and chip select.
// Each burst holds CS low until the MOSI word tagged tlast has shifted out.
module spi_master_burst #(
  parameter int MAX_WIDTH = 32,
  parameter int NUM_CS    = 4,
  parameter int DIV_WIDTH = 16,
  localparam int WW       = $clog2(MAX_WIDTH) + 1,
  localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic [DIV_WIDTH-1:0] cfg_clk_div,
  input  logic [WW-1:0]        cfg_width,
  input  logic [CSW-1:0]       cfg_cs_sel,
  input  logic [MAX_WIDTH-1:0] mosi_tdata,
  input  logic                 mosi_tvalid,
  output logic                 mosi_tready,
  input  logic                 mosi_tlast,
  output logic [MAX_WIDTH-1:0] miso_tdata,
  output logic                 miso_tvalid,
  input  logic                 miso_tready,
  output logic                 miso_tlast,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NUM_CS-1:0]    cs_n,
  output logic                 busy
);

  localparam int ECW = $clog2(2 * MAX_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_NEXT, S_CS_HOLD, S_CS_IDLE
  } state_t;

  state_t                r_state;
  logic                  r_cpol;
  logic                  r_cpha;
  logic [DIV_WIDTH-1:0]  r_h;
  logic [WW-1:0]         r_w;
  logic                  r_last;
  logic [MAX_WIDTH-1:0]  r_tx;
  logic [MAX_WIDTH-1:0]  r_rx;
  logic [DIV_WIDTH-1:0]  r_hcnt;
  logic [ECW-1:0]        r_ecnt;
  logic                  r_sck;
  logic                  r_mosi;
  logic [NUM_CS-1:0]     r_cs_n;
  logic                  r_tready;
  logic                  r_busy;
  logic [MAX_WIDTH-1:0]  r_miso_tdata;
  logic                  r_miso_tvalid;
  logic                  r_miso_tlast;

  logic [DIV_WIDTH-1:0]  w_h;
  logic [WW-1:0]         w_w;
  logic [WW-1:0]         w_word_w;
  logic [MAX_WIDTH-1:0]  w_tx_al;
  logic [NUM_CS-1:0]     w_cs_dec;
  logic                  w_hs;
  logic                  w_half_done;
  logic                  w_sample;
  logic [ECW-1:0]        w_last_edge;
  logic [MAX_WIDTH-1:0]  w_rx_nxt;
  logic                  w_miso_keep;

  assign w_h      = (cfg_clk_div == '0) ? DIV_WIDTH'(1) : cfg_clk_div;
  assign w_w      = (cfg_width == '0 || cfg_width > WW'(MAX_WIDTH)) ? WW'(MAX_WIDTH) : cfg_width;
  // First word of a burst uses the live width; later words use the frozen one.
  assign w_word_w = (r_state == S_IDLE) ? w_w : r_w;
  assign w_tx_al  = mosi_tdata << (MAX_WIDTH - int'(w_word_w));

  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cfg_cs_sel) == i) w_cs_dec[i] = 1'b0;
    end
  end

  assign w_hs        = mosi_tvalid & r_tready;
  assign w_half_done = (r_hcnt == r_h - DIV_WIDTH'(1));
  // Edge number is r_ecnt+1, so odd edges have r_ecnt[0]==0.
  assign w_sample    = (r_ecnt[0] == r_cpha);
  assign w_last_edge = (ECW'(r_w) << 1) - ECW'(1);
  assign w_rx_nxt    = w_sample ? {r_rx[MAX_WIDTH-2:0], miso} : r_rx;
  assign w_miso_keep = r_miso_tvalid & ~miso_tready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_h           <= DIV_WIDTH'(1);
      r_w           <= WW'(MAX_WIDTH);
      r_last        <= 1'b0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_hcnt        <= '0;
      r_ecnt        <= '0;
      r_sck         <= 1'b0;
      r_mosi        <= 1'b0;
      r_cs_n        <= '1;
      r_tready      <= 1'b0;
      r_busy        <= 1'b0;
      r_miso_tdata  <= '0;
      r_miso_tvalid <= 1'b0;
      r_miso_tlast  <= 1'b0;
    end else begin
      if (r_miso_tvalid && miso_tready) r_miso_tvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_sck    <= cfg_cpol;
          r_tready <= ~w_miso_keep;
          if (w_hs) begin
            r_tready <= 1'b0;
            r_busy   <= 1'b1;
            r_cpol   <= cfg_cpol;
            r_cpha   <= cfg_cpha;
            r_h      <= w_h;
            r_w      <= w_w;
            r_cs_n   <= w_cs_dec;
            r_last   <= mosi_tlast;
            r_rx     <= '0;
            r_hcnt   <= '0;
            r_ecnt   <= '0;
            r_tx     <= cfg_cpha ? w_tx_al : (w_tx_al << 1);
            if (!cfg_cpha) r_mosi <= w_tx_al[MAX_WIDTH-1];
            r_state  <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (w_half_done) begin
            r_hcnt  <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_hcnt <= r_hcnt + DIV_WIDTH'(1);
          end
        end

        S_SHIFT: begin
          if (w_half_done) begin
            r_hcnt <= '0;
            r_sck  <= ~r_sck;
            r_ecnt <= r_ecnt + ECW'(1);
            if (w_sample) begin
              r_rx <= w_rx_nxt;
            end else begin
              r_mosi <= r_tx[MAX_WIDTH-1];
              r_tx   <= r_tx << 1;
            end
            if (r_ecnt == w_last_edge) begin
              r_ecnt        <= '0;
              r_miso_tvalid <= 1'b1;
              r_miso_tdata  <= w_rx_nxt;
              r_miso_tlast  <= r_last;
              r_state       <= r_last ? S_CS_HOLD : S_NEXT;
            end
          end else begin
            r_hcnt <= r_hcnt + DIV_WIDTH'(1);
          end
        end

        S_NEXT: begin
          r_sck    <= r_cpol;
          r_tready <= ~w_miso_keep;
          if (w_hs) begin
            r_tready <= 1'b0;
            r_last   <= mosi_tlast;
            r_rx     <= '0;
            r_hcnt   <= '0;
            r_tx     <= r_cpha ? w_tx_al : (w_tx_al << 1);
            if (!r_cpha) r_mosi <= w_tx_al[MAX_WIDTH-1];
            r_state  <= S_SHIFT;
          end
        end

        S_CS_HOLD: begin
          if (w_half_done) begin
            r_hcnt  <= '0;
            r_cs_n  <= '1;
            r_state <= S_CS_IDLE;
          end else begin
            r_hcnt <= r_hcnt + DIV_WIDTH'(1);
          end
        end

        S_CS_IDLE: begin
          if (w_half_done) begin
            r_hcnt  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hcnt <= r_hcnt + DIV_WIDTH'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sck         = r_sck;
  assign mosi        = r_mosi;
  assign cs_n        = r_cs_n;
  assign busy        = r_busy;
  assign mosi_tready = r_tready;
  assign miso_tdata  = r_miso_tdata;
  assign miso_tvalid = r_miso_tvalid;
  assign miso_tlast  = r_miso_tlast;

endmodule
